// File: rtl/ras_ckpt_pkg.sv
// Shared branch-prediction types for the core: RAS configuration, stack op
// decode and the return-stack checkpoint record.
package ras_ckpt_pkg;

    localparam int CORE_XLEN      = 32;
    localparam int CORE_RAS_DEPTH = 2;
    localparam int CORE_RAS_PTR_W = $clog2(CORE_RAS_DEPTH);

    typedef enum logic [1:0] {
        RAS_NONE     = 2'd0,
        RAS_PUSH     = 2'd1,
        RAS_POP      = 2'd2,
        RAS_PUSH_POP = 2'd3
    } ras_op_e;

    // Checkpoint record at the core's configured XLEN / RAS depth.
    typedef struct packed {
        logic [CORE_RAS_PTR_W-1:0] tos;
        logic [CORE_RAS_PTR_W:0]   count;
        logic [CORE_XLEN-1:0]      top;
    } ras_ckpt_t;

    function automatic ras_op_e ras_op_decode(input logic push, input logic pop);
        return ras_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/ras_ckpt.sv
// Return-address stack on a circular buffer with checkpoint save/restore so
// mispredicted speculation can repair tos, count and an overwritten top entry.
module ras_ckpt
    import ras_ckpt_pkg::*;
#(
    parameter int XLEN  = CORE_XLEN,
    parameter int DEPTH = CORE_RAS_DEPTH,
    parameter int NCKPT = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1,
    localparam int IW   = (NCKPT > 1) ? $clog2(NCKPT) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_addr_i,
    input  logic            pop_i,
    input  logic            ckpt_save_i,
    input  logic [IW-1:0]   ckpt_save_id_i,
    input  logic            ckpt_restore_i,
    input  logic [IW-1:0]   ckpt_restore_id_i,
    output logic [XLEN-1:0] data_o,
    output logic            valid_o,
    output logic [CW-1:0]   count_o,
    output logic            overflow_o,
    output logic            underflow_o
);

    localparam int NSLOT = 1 << IW;
    localparam logic [NSLOT-1:0] ID_OK = {NSLOT{1'b1}} >> (NSLOT - NCKPT);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [PW-1:0]   tos;
        logic [CW-1:0]   count;
        logic [XLEN-1:0] top;
    } ckpt_t;

    logic [XLEN-1:0]  stack_q [DEPTH];
    logic [PW-1:0]    tos_q, tos_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    ckpt_t            ckpt_q [NSLOT];
    logic [NSLOT-1:0] ckpt_vld_q, ckpt_vld_d;

    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic [XLEN-1:0]  wr_data;
    logic             save_en;
    ckpt_t            rst_slot;

    always_comb begin
        tos_d      = tos_q;
        count_d    = count_q;
        ovf_d      = 1'b0;
        udf_d      = 1'b0;
        ckpt_vld_d = ckpt_vld_q;
        wr_en      = 1'b0;
        wr_idx     = tos_q;
        wr_data    = push_addr_i;
        save_en    = 1'b0;
        rst_slot   = ckpt_q[ckpt_restore_id_i];

        if (flush_i) begin
            tos_d      = '0;
            count_d    = '0;
            ckpt_vld_d = '0;
        end else if (ckpt_restore_i) begin
            // Rewriting the saved top repairs an entry clobbered by wrong-path pushes.
            if (ID_OK[ckpt_restore_id_i] && ckpt_vld_q[ckpt_restore_id_i]) begin
                tos_d   = rst_slot.tos;
                count_d = rst_slot.count;
                wr_en   = 1'b1;
                wr_idx  = rst_slot.tos;
                wr_data = rst_slot.top;
            end
        end else begin
            save_en = ckpt_save_i && ID_OK[ckpt_save_id_i];
            if (save_en) ckpt_vld_d[ckpt_save_id_i] = 1'b1;

            unique case (ras_op_decode(push_i, pop_i))
                RAS_PUSH_POP: begin
                    if (count_q == '0) begin
                        tos_d   = tos_q + PW'(1);
                        count_d = CW'(1);
                        wr_en   = 1'b1;
                        wr_idx  = tos_q + PW'(1);
                    end else begin
                        wr_en = 1'b1;
                    end
                end
                RAS_PUSH: begin
                    tos_d  = tos_q + PW'(1);
                    wr_en  = 1'b1;
                    wr_idx = tos_q + PW'(1);
                    if (count_q == FULL) ovf_d = 1'b1;
                    else                 count_d = count_q + CW'(1);
                end
                RAS_POP: begin
                    if (count_q == '0) begin
                        udf_d = 1'b1;
                    end else begin
                        tos_d   = tos_q - PW'(1);
                        count_d = count_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tos_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            ckpt_vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            for (int i = 0; i < NSLOT; i++) ckpt_q[i] <= '0;
        end else begin
            tos_q      <= tos_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            ckpt_vld_q <= ckpt_vld_d;
            if (wr_en) stack_q[wr_idx] <= wr_data;
            if (save_en) ckpt_q[ckpt_save_id_i] <= '{tos: tos_q, count: count_q, top: stack_q[tos_q]};
        end
    end

    assign data_o      = (count_q != '0) ? stack_q[tos_q] : '0;
    assign valid_o     = (count_q != '0);
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: directed scenarios plus random traffic
// checked against a behavioural stack/checkpoint model.
module tb_ras_ckpt;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int NCKPT = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int IW    = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush_i, push_i, pop_i, ckpt_save_i, ckpt_restore_i;
    logic [XLEN-1:0] push_addr_i;
    logic [IW-1:0]   ckpt_save_id_i, ckpt_restore_id_i;
    logic [XLEN-1:0] data_o;
    logic            valid_o, overflow_o, underflow_o;
    logic [CW-1:0]   count_o;

    int errors = 0;
    int checks = 0;
    logic [XLEN-1:0] exp_q[$];

    // Behavioural model: physical array indexed modulo DEPTH, plain ints for tos/count.
    int              m_tos, m_cnt;
    logic [XLEN-1:0] m_mem [DEPTH];
    int              s_tos [NCKPT];
    int              s_cnt [NCKPT];
    logic [XLEN-1:0] s_top [NCKPT];
    bit              s_vld [NCKPT];
    bit              m_ovf, m_udf;

    ras_ckpt #(.XLEN(XLEN), .DEPTH(DEPTH), .NCKPT(NCKPT)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush_i),
        .push_i            (push_i),
        .push_addr_i       (push_addr_i),
        .pop_i             (pop_i),
        .ckpt_save_i       (ckpt_save_i),
        .ckpt_save_id_i    (ckpt_save_id_i),
        .ckpt_restore_i    (ckpt_restore_i),
        .ckpt_restore_id_i (ckpt_restore_id_i),
        .data_o            (data_o),
        .valid_o           (valid_o),
        .count_o           (count_o),
        .overflow_o        (overflow_o),
        .underflow_o       (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_tos = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int i = 0; i < NCKPT; i++) begin
            s_tos[i] = 0; s_cnt[i] = 0; s_top[i] = '0; s_vld[i] = 0;
        end
    endtask

    task automatic model_step(input bit fl, input bit rs, input int rid, input bit sv,
                              input int sid, input bit ps, input logic [XLEN-1:0] a,
                              input bit pp);
        m_ovf = 0; m_udf = 0;
        if (fl) begin
            m_tos = 0; m_cnt = 0;
            for (int i = 0; i < NCKPT; i++) s_vld[i] = 0;
        end else if (rs) begin
            if (rid < NCKPT && s_vld[rid]) begin
                m_tos = s_tos[rid]; m_cnt = s_cnt[rid]; m_mem[m_tos] = s_top[rid];
            end
        end else begin
            if (sv && sid < NCKPT) begin
                s_tos[sid] = m_tos; s_cnt[sid] = m_cnt; s_top[sid] = m_mem[m_tos]; s_vld[sid] = 1;
            end
            if (ps && pp && m_cnt > 0) begin
                m_mem[m_tos] = a;
            end else if (ps) begin
                m_tos = (m_tos + 1) % DEPTH;
                m_mem[m_tos] = a;
                if (m_cnt == DEPTH) m_ovf = 1;
                else m_cnt++;
            end else if (pp) begin
                if (m_cnt == 0) m_udf = 1;
                else begin
                    m_tos = (m_tos + DEPTH - 1) % DEPTH;
                    m_cnt--;
                end
            end
        end
    endtask

    // Drives one request cycle from a negedge; returns at the following negedge.
    task automatic op(input bit fl, input bit rs, input int rid, input bit sv, input int sid,
                      input bit ps, input logic [XLEN-1:0] a, input bit pp);
        flush_i = fl; ckpt_restore_i = rs; ckpt_restore_id_i = IW'(rid);
        ckpt_save_i = sv; ckpt_save_id_i = IW'(sid);
        push_i = ps; push_addr_i = a; pop_i = pp;
        @(posedge clk);
        model_step(fl, rs, rid, sv, sid, ps, a, pp);
        @(negedge clk);
        flush_i = 0; ckpt_restore_i = 0; ckpt_save_i = 0; push_i = 0; pop_i = 0;
    endtask

    task automatic push(input logic [XLEN-1:0] a); op(0, 0, 0, 0, 0, 1, a, 0); endtask
    task automatic pop();                          op(0, 0, 0, 0, 0, 0, '0, 1); endtask
    task automatic idle();                         op(0, 0, 0, 0, 0, 0, '0, 0); endtask
    task automatic flush();                        op(1, 0, 0, 0, 0, 0, '0, 0); endtask

    task automatic test_reset();
        checks++;
        if (data_o !== '0 || valid_o !== 1'b0 || count_o !== '0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: data=%h valid=%b count=%0d ovf=%b udf=%b, want all 0",
                     data_o, valid_o, count_o, overflow_o, underflow_o);
        end
    endtask

    task automatic test_overflow();
        flush();
        push(32'h100);
        push(32'h200);
        checks++;
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow_o); end
        push(32'h300);
        checks++;
        if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", overflow_o); end
        checks++;
        if (count_o !== CW'(2)) begin errors++; $display("FAIL ovf_count: got %0d want 2", count_o); end
        idle();
        checks++;
        if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b want 0", overflow_o); end
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h200);
        while (exp_q.size() > 0) begin
            logic [XLEN-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (data_o !== e) begin errors++; $display("FAIL ovf_pop_data: got %h want %h", data_o, e); end
            pop();
        end
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drained: valid got %b want 0", valid_o); end
    endtask

    task automatic test_underflow();
        flush();
        pop();
        checks++;
        if (underflow_o !== 1'b1 || count_o !== '0 || data_o !== '0) begin
            errors++;
            $display("FAIL udf_pulse: udf=%b count=%0d data=%h want 1/0/0", underflow_o, count_o, data_o);
        end
        idle();
        checks++;
        if (underflow_o !== 1'b0) begin errors++; $display("FAIL udf_one_cycle: got %b want 0", underflow_o); end
    endtask

    task automatic test_push_pop();
        flush();
        push(32'h100);
        op(0, 0, 0, 0, 0, 1, 32'h400, 1);
        checks++;
        if (data_o !== 32'h400 || count_o !== CW'(1)) begin
            errors++;
            $display("FAIL push_pop: data=%h count=%0d want 400/1", data_o, count_o);
        end
        flush();
        op(0, 0, 0, 0, 0, 1, 32'h410, 1);
        checks++;
        if (data_o !== 32'h410 || count_o !== CW'(1) || underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_empty: data=%h count=%0d udf=%b want 410/1/0", data_o, count_o, underflow_o);
        end
    endtask

    task automatic test_ckpt_restore();
        flush();
        push(32'h100);
        op(0, 0, 0, 1, 1, 0, '0, 0);
        pop();
        push(32'h500);
        op(0, 1, 1, 0, 0, 0, '0, 0);
        checks++;
        if (data_o !== 32'h100 || count_o !== CW'(1)) begin
            errors++;
            $display("FAIL ckpt_restore: data=%h count=%0d want 100/1", data_o, count_o);
        end
        // Restore takes priority over a same-cycle push.
        op(0, 1, 1, 0, 0, 1, 32'h777, 0);
        checks++;
        if (data_o !== 32'h100 || count_o !== CW'(1)) begin
            errors++;
            $display("FAIL restore_prio: data=%h count=%0d want 100/1", data_o, count_o);
        end
    endtask

    task automatic test_flush_ckpt();
        op(0, 0, 0, 1, 0, 0, '0, 0);
        flush();
        op(0, 1, 0, 0, 0, 0, '0, 0);
        checks++;
        if (count_o !== '0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ckpt: count=%0d valid=%b want 0/0", count_o, valid_o);
        end
        op(1, 0, 0, 0, 0, 1, 32'h999, 0);
        checks++;
        if (count_o !== '0) begin errors++; $display("FAIL flush_prio: count got %0d want 0", count_o); end
    endtask

    task automatic test_reset_mid();
        flush();
        push(32'h600);
        push(32'h610);
        checks++;
        if (count_o !== CW'(2)) begin errors++; $display("FAIL rst_pre_count: got %0d want 2", count_o); end
        push_i = 1; push_addr_i = 32'h620; ckpt_save_i = 1; ckpt_save_id_i = '0;
        #2 rst = 1;
        #1;
        checks++;
        if (data_o !== '0 || valid_o !== 1'b0 || count_o !== '0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: data=%h valid=%b count=%0d ovf=%b udf=%b want all 0",
                     data_o, valid_o, count_o, overflow_o, underflow_o);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (count_o !== '0) begin errors++; $display("FAIL rst_discard: count got %0d want 0", count_o); end
        rst = 0; push_i = 0; ckpt_save_i = 0;
        model_reset();
        push(32'h700);
        checks++;
        if (count_o !== CW'(1) || data_o !== 32'h700) begin
            errors++;
            $display("FAIL rst_after_push: count=%0d data=%h want 1/700", count_o, data_o);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit fl, rs, sv, ps, pp;
            int rid, sid;
            logic [XLEN-1:0] exp_data;
            fl  = ($urandom_range(0, 31) == 0);
            rs  = ($urandom_range(0, 7) == 0);
            sv  = ($urandom_range(0, 3) == 0);
            ps  = $urandom_range(0, 1) == 1;
            pp  = $urandom_range(0, 2) == 0;
            rid = $urandom_range(0, NCKPT - 1);
            sid = $urandom_range(0, NCKPT - 1);
            op(fl, rs, rid, sv, sid, ps, $urandom, pp);
            exp_data = (m_cnt > 0) ? m_mem[m_tos] : '0;
            checks++;
            if (data_o !== exp_data || valid_o !== (m_cnt > 0) || count_o !== CW'(m_cnt) ||
                overflow_o !== m_ovf || underflow_o !== m_udf) begin
                errors++;
                $display("FAIL random[%0d]: data=%h valid=%b count=%0d ovf=%b udf=%b want %h/%b/%0d/%b/%b",
                         n, data_o, valid_o, count_o, overflow_o, underflow_o,
                         exp_data, m_cnt > 0, m_cnt, m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        rst = 1; flush_i = 0; push_i = 0; pop_i = 0; push_addr_i = '0;
        ckpt_save_i = 0; ckpt_restore_i = 0; ckpt_save_id_i = '0; ckpt_restore_id_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        test_reset();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_ckpt_restore();
        test_flush_ckpt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
